cv32e40s_sha2_unit: RTL and testbench
=====================================

CV32E40S_SHA2_UNIT -- requirements
Module: cv32e40s_sha2_unit

Interface
REQ-001 Parameter SHA512, default 0: 1 enables the RV32 SHA-512 ops (Zknh sha512*); 0 makes them illegal.
REQ-002 Parameter LATENCY, default 1: cycles from accept to out_valid_o (legal values 1 or 2); any other value SHALL fail elaboration.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid_i  input  1  operation request valid.
REQ-006 in_ready_o  output  1  unit can accept a request this cycle.
REQ-007 op_i  input  4  0 SIG0, 1 SIG1, 2 SUM0, 3 SUM1 (sha256*); 4 SIG0L, 5 SIG0H, 6 SIG1L, 7 SIG1H, 8 SUM0R, 9 SUM1R (sha512*); 10-15 reserved.
REQ-008 rs1_i  input  32  operand 1.
REQ-009 rs2_i  input  32  operand 2 (used by sha512 ops only).
REQ-010 kill_i  input  1  flush in-flight and held result (pipeline kill from controller).
REQ-011 out_valid_o  output  1  result valid.
REQ-012 out_ready_i  input  1  consumer takes result.
REQ-013 result_o  output  32  computed value.
REQ-014 err_o  output  1  qualifies result_o: op was illegal.

Function
REQ-015 Arithmetic SHALL match RISC-V Scalar Cryptography v1.0.1 Zknh exactly; SIG0 = ror7^ror18^srl3, SIG1 = ror17^ror19^srl10, SUM0 = ror2^ror13^ror22, SUM1 = ror6^ror11^ror25; sha512 RV32 ops use the {rs1,rs2} formulas of that spec; all results truncated to 32 bits.
REQ-016 FSM states IDLE, CALC, DONE; CALC is reachable only when LATENCY=2.
REQ-017 Accept = in_valid_i & in_ready_o; operands and op SHALL be captured at accept and SHALL be unaffected by later input changes.
REQ-018 in_ready_o = !rst & !kill_i & (state==IDLE | (state==DONE & out_ready_i)).
REQ-019 Accept with LATENCY=1 SHALL go to DONE; accept with LATENCY=2 SHALL go to CALC; CALC SHALL go to DONE unconditionally on the next cycle.
REQ-020 out_valid_o SHALL be 1 exactly in DONE; result_o and err_o SHALL be stable while out_valid_o=1 & out_ready_i=0.
REQ-021 DONE & out_ready_i & no accept SHALL go to IDLE; DONE & out_ready_i & accept SHALL go to DONE (L=1) or CALC (L=2), giving throughput 1/cycle (L=1) or 1 per 2 cycles (L=2).
REQ-022 LATENCY=2 SHALL split the work across two register stages: stage 1 registers the rotate/shift terms, stage 2 XOR-combines them. The datapath registers SHALL NOT be reused between the two stages.
REQ-023 Illegal op (op 10-15, or op 4-9 with SHA512=0): complete with normal timing, result_o=0, err_o=1.
REQ-024 err_o=0 and result_o=0 SHALL hold whenever out_valid_o=0.
REQ-025 kill_i=1 SHALL force next state IDLE from any state; kill wins over a simultaneous accept or consume; out_valid_o=0 the next cycle.
REQ-026 An unconsumed result SHALL never be overwritten.

Reset
REQ-027 While rst=1 at a clock edge, the next state SHALL be IDLE, out_valid_o=0, result_o=0, err_o=0, and all pipeline registers cleared; in_ready_o=0 during rst.
REQ-028 Reset mid-operation (CALC or DONE) SHALL discard the operation with no output; in_ready_o=1 in the first cycle after rst deasserts.

Verification
REQ-029 LATENCY=1, ops 0/1/2/3 with rs1=0x00000001 and out_ready_i=1 -> results 0x02004000, 0x0000A000, 0x40080400, 0x04200080 one cycle after each accept, back-to-back with no bubbles.
REQ-030 SHA512=1, LATENCY=2, op 8 (SUM0R) with rs1=0x00000001, rs2=0 -> out_valid_o two cycles after accept, result_o=0x42000000, err_o=0.
REQ-031 SHA512=0, op 5 -> out_valid_o with result_o=0 and err_o=1; op 12 with any SHA512 value gives the same result.
REQ-032 Backpressure: out_ready_i=0 for 5 cycles with in_valid_i held high -> in_ready_o=0 and result_o stable; out_ready_i=1 -> consume and accept in the same cycle.
REQ-033 kill_i asserted in CALC, and kill_i asserted together with in_valid_i in DONE -> no out_valid_o next cycle, no accept, state IDLE.
REQ-034 rst pulsed in DONE -> outputs zero next cycle; a fresh request afterward completes correctly.

Source files
------------

// File: rtl/cv32e40s_sha2_unit.sv
// SHA-256 / RV32 SHA-512 sigma and sum unit (Zknh) behind a valid/ready handshake.
// Holds one result at a time. LATENCY=2 adds a register stage for the rotate/shift terms.
module cv32e40s_sha2_unit #(
    parameter int SHA512  = 0,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  op_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        kill_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [5:0][31:0] terms_t;

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("cv32e40s_sha2_unit: LATENCY must be 1 or 2");
    end

    localparam state_e ACCEPT_STATE = (LATENCY == 2) ? CALC : DONE;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        if (op <= 4'd3) begin
            ok = 1'b1;
        end else if (op <= 4'd9) begin
            ok = (SHA512 != 0);
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Up to six terms per op; unused slots stay zero so a plain XOR of all six is the result.
    function automatic terms_t op_terms(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        terms_t t;
        t = '0;
        case (op)
            4'd0: begin t[0] = ror32(a, 5'd7);  t[1] = ror32(a, 5'd18); t[2] = a >> 5'd3;  end
            4'd1: begin t[0] = ror32(a, 5'd17); t[1] = ror32(a, 5'd19); t[2] = a >> 5'd10; end
            4'd2: begin t[0] = ror32(a, 5'd2);  t[1] = ror32(a, 5'd13); t[2] = ror32(a, 5'd22); end
            4'd3: begin t[0] = ror32(a, 5'd6);  t[1] = ror32(a, 5'd11); t[2] = ror32(a, 5'd25); end
            4'd4: begin
                t[0] = a >> 5'd1;  t[1] = a >> 5'd7;  t[2] = a >> 5'd8;
                t[3] = b << 5'd31; t[4] = b << 5'd25; t[5] = b << 5'd24;
            end
            4'd5: begin
                t[0] = a >> 5'd1;  t[1] = a >> 5'd7;  t[2] = a >> 5'd8;
                t[3] = b << 5'd31; t[4] = b << 5'd24;
            end
            4'd6: begin
                t[0] = a << 5'd3;  t[1] = a >> 5'd6;  t[2] = a >> 5'd19;
                t[3] = b >> 5'd29; t[4] = b << 5'd26; t[5] = b << 5'd13;
            end
            4'd7: begin
                t[0] = a << 5'd3;  t[1] = a >> 5'd6;  t[2] = a >> 5'd19;
                t[3] = b >> 5'd29; t[4] = b << 5'd13;
            end
            4'd8: begin
                t[0] = a << 5'd25; t[1] = a << 5'd30; t[2] = a >> 5'd28;
                t[3] = b >> 5'd7;  t[4] = b >> 5'd2;  t[5] = b << 5'd4;
            end
            4'd9: begin
                t[0] = a << 5'd23; t[1] = a >> 5'd14; t[2] = a >> 5'd18;
                t[3] = b >> 5'd9;  t[4] = b << 5'd18; t[5] = b << 5'd14;
            end
            default: t = '0;
        endcase
        if (!op_legal(op)) begin
            t = '0;
        end
        return t;
    endfunction

    function automatic logic [31:0] xor_terms(input terms_t t);
        return t[0] ^ t[1] ^ t[2] ^ t[3] ^ t[4] ^ t[5];
    endfunction

    state_e      r_state;
    state_e      w_next_state;
    logic        w_accept;
    terms_t      w_terms;
    logic        w_legal;
    logic        w_load;
    logic [31:0] w_new_result;
    logic        w_new_err;
    logic [31:0] r_result;
    logic        r_err;

    assign w_accept = in_valid_i & in_ready_o;
    assign w_terms  = op_terms(op_i, rs1_i, rs2_i);
    assign w_legal  = op_legal(op_i);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; kill overrides any accept or consume.
    always_comb begin
        w_next_state = r_state;
        if (kill_i) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) w_next_state = ACCEPT_STATE;
                    else          w_next_state = IDLE;
                end
                CALC: w_next_state = DONE;
                DONE: begin
                    if (!out_ready_i)  w_next_state = DONE;
                    else if (w_accept) w_next_state = ACCEPT_STATE;
                    else               w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        if (!rst && !kill_i && (r_state == IDLE || (r_state == DONE && out_ready_i))) begin
            in_ready_o = 1'b1;
        end else begin
            in_ready_o = 1'b0;
        end
        out_valid_o = (r_state == DONE);
    end

    if (LATENCY == 2) begin : g_two_stage
        terms_t r_s1_terms;
        logic   r_s1_err;

        // Stage 1: captures the rotate/shift terms of the accepted operands.
        always_ff @(posedge clk) begin
            if (rst || kill_i) begin
                r_s1_terms <= '0;
                r_s1_err   <= 1'b0;
            end else if (w_accept) begin
                r_s1_terms <= w_terms;
                r_s1_err   <= !w_legal;
            end
        end

        assign w_new_result = xor_terms(r_s1_terms);
        assign w_new_err    = r_s1_err;
        assign w_load       = (r_state == CALC);
    end else begin : g_one_stage
        assign w_new_result = xor_terms(w_terms);
        assign w_new_err    = !w_legal;
        assign w_load       = w_accept;
    end

    // Result stage: loads on entry to DONE, holds while stalled, zero whenever not in DONE.
    always_ff @(posedge clk) begin
        if (rst || kill_i) begin
            r_result <= 32'd0;
            r_err    <= 1'b0;
        end else if (w_load) begin
            r_result <= w_new_result;
            r_err    <= w_new_err;
        end else if (w_next_state != DONE) begin
            r_result <= 32'd0;
            r_err    <= 1'b0;
        end
    end

    assign result_o = r_result;
    assign err_o    = r_err;

endmodule

// File: tb/tb_cv32e40s_sha2_unit.sv
// Directed and randomized checks of cv32e40s_sha2_unit against a 64-bit rotate reference model.
module tb_cv32e40s_sha2_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        kill = 1'b0;
    logic        oready = 1'b0;

    logic        a_ready, a_ovalid, a_err;
    logic [31:0] a_res;
    logic        b_ready, b_ovalid, b_err;
    logic [31:0] b_res;

    int total = 0;
    int bad   = 0;

    logic [31:0] v1, v2, exp_r;
    logic        exp_e;
    logic [31:0] exp029 [4];

    cv32e40s_sha2_unit #(.SHA512(0), .LATENCY(1)) u_a (
        .clk(clk), .rst(rst), .in_valid_i(a_valid), .in_ready_o(a_ready),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .kill_i(kill),
        .out_valid_o(a_ovalid), .out_ready_i(oready), .result_o(a_res), .err_o(a_err)
    );

    cv32e40s_sha2_unit #(.SHA512(1), .LATENCY(2)) u_b (
        .clk(clk), .rst(rst), .in_valid_i(b_valid), .in_ready_o(b_ready),
        .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .kill_i(kill),
        .out_valid_o(b_ovalid), .out_ready_i(oready), .result_o(b_res), .err_o(b_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // SHA-512 RV32 ops are halves of the 64-bit functions applied to {rs2,rs1} or {rs1,rs2}.
    task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit sha512, output logic [31:0] r, output logic e);
        logic [63:0] x, y, v;
        x = {b, a};
        y = {a, b};
        v = 64'd0;
        r = 32'd0;
        e = 1'b0;
        case (o)
            4'd0: r = r32(a, 7) ^ r32(a, 18) ^ (a >> 3);
            4'd1: r = r32(a, 17) ^ r32(a, 19) ^ (a >> 10);
            4'd2: r = r32(a, 2) ^ r32(a, 13) ^ r32(a, 22);
            4'd3: r = r32(a, 6) ^ r32(a, 11) ^ r32(a, 25);
            4'd4: begin v = r64(x, 1) ^ r64(x, 8) ^ (x >> 7);    r = v[31:0];  end
            4'd5: begin v = r64(y, 1) ^ r64(y, 8) ^ (y >> 7);    r = v[63:32]; end
            4'd6: begin v = r64(x, 19) ^ r64(x, 61) ^ (x >> 6);  r = v[31:0];  end
            4'd7: begin v = r64(y, 19) ^ r64(y, 61) ^ (y >> 6);  r = v[63:32]; end
            4'd8: begin v = r64(x, 28) ^ r64(x, 34) ^ r64(x, 39); r = v[31:0]; end
            4'd9: begin v = r64(x, 14) ^ r64(x, 18) ^ r64(x, 41); r = v[31:0]; end
            default: begin r = 32'd0; e = 1'b1; end
        endcase
        if (o >= 4'd4 && o <= 4'd9 && !sha512) begin
            r = 32'd0;
            e = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Random traffic on one unit; a one-deep scoreboard tracks the outstanding result.
    task automatic run_random(input bit sel, input int cycles);
        logic [31:0] q_res[$];
        logic        q_err[$];
        logic        rdy, vld, e, inv, held, held_e, m_e;
        logic [31:0] r, held_r, m_r;
        held = 1'b0;
        held_r = 32'd0;
        held_e = 1'b0;
        for (int c = 0; c < cycles + 6; c++) begin
            if (c < cycles) begin
                op     = 4'($urandom_range(0, 15));
                rs1    = $urandom;
                rs2    = $urandom;
                oready = ($urandom_range(0, 3) != 0);
                inv    = 1'($urandom_range(0, 1));
            end else begin
                oready = 1'b1;
                inv    = 1'b0;
            end
            if (sel) b_valid = inv; else a_valid = inv;
            #1;
            rdy = sel ? b_ready  : a_ready;
            vld = sel ? b_ovalid : a_ovalid;
            r   = sel ? b_res    : a_res;
            e   = sel ? b_err    : a_err;
            if (!vld) begin
                chk("rnd_idle_res", r, 32'd0);
                chk("rnd_idle_err", {31'd0, e}, 32'd0);
                held = 1'b0;
            end else begin
                chk("rnd_pending", q_res.size(), 32'd1);
                if (held) begin
                    chk("rnd_stable_res", r, held_r);
                    chk("rnd_stable_err", {31'd0, e}, {31'd0, held_e});
                end
                if (q_res.size() > 0) begin
                    chk("rnd_res", r, q_res[0]);
                    chk("rnd_err", {31'd0, e}, {31'd0, q_err[0]});
                    if (oready) begin
                        void'(q_res.pop_front());
                        void'(q_err.pop_front());
                    end
                end
                held   = !oready;
                held_r = r;
                held_e = e;
            end
            if (inv && rdy) begin
                model(op, rs1, rs2, sel, m_r, m_e);
                q_res.push_back(m_r);
                q_err.push_back(m_e);
            end
            tick();
        end
        chk("rnd_drained", q_res.size(), 32'd0);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        exp029[0] = 32'h02004000;
        exp029[1] = 32'h0000A000;
        exp029[2] = 32'h40080400;
        exp029[3] = 32'h04200080;

        // Reset state
        tick();
        tick();
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
        chk("rst_a_valid", {31'd0, a_ovalid}, 32'd0);
        chk("rst_b_valid", {31'd0, b_ovalid}, 32'd0);
        chk("rst_a_res", a_res, 32'd0);
        chk("rst_a_err", {31'd0, a_err}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_a_ready", {31'd0, a_ready}, 32'd1);
        chk("post_rst_b_ready", {31'd0, b_ready}, 32'd1);

        // Back-to-back sha256 ops, LATENCY=1
        oready = 1'b1;
        rs1 = 32'h00000001;
        rs2 = 32'h0;
        a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            op = 4'(i);
            #1;
            chk("b2b_ready", {31'd0, a_ready}, 32'd1);
            tick();
            chk("b2b_valid", {31'd0, a_ovalid}, 32'd1);
            chk("b2b_res", a_res, exp029[i]);
            chk("b2b_err", {31'd0, a_err}, 32'd0);
        end
        a_valid = 1'b0;
        tick();
        chk("b2b_end_valid", {31'd0, a_ovalid}, 32'd0);
        chk("b2b_end_res", a_res, 32'd0);

        // Illegal ops on the SHA512=0 unit
        rs1 = $urandom;
        rs2 = $urandom;
        op = 4'd5;
        a_valid = 1'b1;
        tick();
        chk("ill5_valid", {31'd0, a_ovalid}, 32'd1);
        chk("ill5_res", a_res, 32'd0);
        chk("ill5_err", {31'd0, a_err}, 32'd1);
        op = 4'd12;
        tick();
        chk("ill12_res", a_res, 32'd0);
        chk("ill12_err", {31'd0, a_err}, 32'd1);
        a_valid = 1'b0;
        tick();
        chk("ill_end_err", {31'd0, a_err}, 32'd0);

        // Backpressure: result held, no accept, then consume+accept together
        v1 = $urandom;
        v2 = $urandom;
        oready = 1'b0;
        op = 4'd0;
        rs1 = v1;
        a_valid = 1'b1;
        tick();
        model(4'd0, v1, rs2, 1'b0, exp_r, exp_e);
        op = 4'd3;
        rs1 = v2;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", {31'd0, a_ready}, 32'd0);
            chk("bp_valid", {31'd0, a_ovalid}, 32'd1);
            chk("bp_res", a_res, exp_r);
            tick();
        end
        oready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, a_ready}, 32'd1);
        tick();
        model(4'd3, v2, rs2, 1'b0, exp_r, exp_e);
        chk("bp_next_valid", {31'd0, a_ovalid}, 32'd1);
        chk("bp_next_res", a_res, exp_r);
        a_valid = 1'b0;
        tick();
        chk("bp_end_valid", {31'd0, a_ovalid}, 32'd0);

        // Kill in DONE together with a new request
        oready = 1'b0;
        op = 4'd1;
        rs1 = v1;
        a_valid = 1'b1;
        tick();
        chk("kd_valid", {31'd0, a_ovalid}, 32'd1);
        kill = 1'b1;
        oready = 1'b1;
        #1;
        chk("kd_ready", {31'd0, a_ready}, 32'd0);
        tick();
        chk("kd_after_valid", {31'd0, a_ovalid}, 32'd0);
        chk("kd_after_res", a_res, 32'd0);
        kill = 1'b0;
        a_valid = 1'b0;
        #1;
        chk("kd_idle_ready", {31'd0, a_ready}, 32'd1);

        // Reset while in DONE, then a fresh request
        oready = 1'b0;
        op = 4'd2;
        a_valid = 1'b1;
        tick();
        chk("rd_valid", {31'd0, a_ovalid}, 32'd1);
        a_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rd_after_valid", {31'd0, a_ovalid}, 32'd0);
        chk("rd_after_res", a_res, 32'd0);
        rst = 1'b0;
        #1;
        chk("rd_ready", {31'd0, a_ready}, 32'd1);
        rs1 = v2;
        oready = 1'b1;
        a_valid = 1'b1;
        tick();
        model(4'd2, v2, rs2, 1'b0, exp_r, exp_e);
        chk("rd_fresh_valid", {31'd0, a_ovalid}, 32'd1);
        chk("rd_fresh_res", a_res, exp_r);
        a_valid = 1'b0;
        tick();

        // SUM0R on the SHA512=1 LATENCY=2 unit; operands changed after accept
        op = 4'd8;
        rs1 = 32'h00000001;
        rs2 = 32'h0;
        b_valid = 1'b1;
        tick();
        chk("s0r_calc_valid", {31'd0, b_ovalid}, 32'd0);
        chk("s0r_calc_res", b_res, 32'd0);
        b_valid = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        #1;
        chk("s0r_calc_ready", {31'd0, b_ready}, 32'd0);
        tick();
        chk("s0r_valid", {31'd0, b_ovalid}, 32'd1);
        chk("s0r_res", b_res, 32'h42000000);
        chk("s0r_err", {31'd0, b_err}, 32'd0);
        tick();
        chk("s0r_end_valid", {31'd0, b_ovalid}, 32'd0);

        // Kill in CALC
        op = 4'd6;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        kill = 1'b1;
        tick();
        chk("kc_valid", {31'd0, b_ovalid}, 32'd0);
        kill = 1'b0;
        tick();
        chk("kc_valid2", {31'd0, b_ovalid}, 32'd0);
        chk("kc_ready", {31'd0, b_ready}, 32'd1);

        // Reserved op on the SHA512=1 unit
        op = 4'd12;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        tick();
        chk("b_ill_valid", {31'd0, b_ovalid}, 32'd1);
        chk("b_ill_res", b_res, 32'd0);
        chk("b_ill_err", {31'd0, b_err}, 32'd1);
        tick();

        run_random(1'b0, 300);
        run_random(1'b1, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
